// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch front end.
//               Holds the datapath widths, the canonical NOP, the queue entry
//               type {pc, instr} and a PC alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // addi x0, x0, 0 - presented on out_instr whenever the queue head is empty
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Clears the two low bits; masking keeps every input bit in the cone so
    // the discarded bits do not show up as unused logic.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue_if
// Description : Bus bundle of the fetch front end.
//               imem_req_*  : fetch request toward instruction memory
//               imem_rsp_*  : in-order instruction responses
//               redirect_*  : taken branch/jump from MEM
//               out_*       : queue head toward the IF/ID register
//               master = fetch unit side, slave = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_queue_if;
    import fetch_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [ILEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_instr, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_instr, out_pc,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with synchronous flush.
//               i_push/i_push_data : write side
//               i_pop/o_pop_data   : read side, o_pop_data is the current head
//               i_flush            : empties the FIFO, wins over push/pop
//               o_count/o_full/o_empty : occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    // Storage needs no reset: r_count gates every read of it.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            r_count <= r_count + c_cnt_w'(i_push) - c_cnt_w'(i_pop);
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_full     = (r_count == c_cnt_w'(DEPTH));
    assign o_empty    = (r_count == '0);

    a_no_overflow : assert property (@(posedge clk) disable iff (rst || i_flush)
        !(i_push && !i_pop && o_full));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst || i_flush)
        !(i_pop && o_empty));

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : RV32 fetch front end. Generates the fetch PC, issues in-order
//               requests to instruction memory under a credit limit of DEPTH
//               (queued + in flight), buffers responses with their PCs, and
//               drains them into IF/ID with a valid/ready handshake. A redirect
//               flushes the queue and marks every in-flight response stale.
//               clk, rst : clock, synchronous active-high reset
//               bus      : instr_fetch_queue_if.master (imem req/rsp, redirect,
//                          IF/ID output)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_queue_if.master bus
);

    localparam int                 c_cnt_w        = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w:0]   c_credit_limit = (c_cnt_w + 1)'(DEPTH);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_rsp_pc;
    logic [c_cnt_w-1:0] r_outstanding;
    logic [c_cnt_w-1:0] r_drop;

    logic [c_cnt_w-1:0] w_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [$bits(fetch_entry_t)-1:0] w_pop_data;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_entry;
    logic [c_cnt_w:0]   w_credit_used;
    logic               w_req_fire;
    logic               w_rsp_stale;
    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_rsp_dec;

    // Every slot the queue might need is reserved at request time, so a
    // response can always be accepted without back-pressuring memory.
    assign w_credit_used = {1'b0, w_count} + {1'b0, r_outstanding};

    assign bus.imem_req_valid = !bus.redirect_valid && (w_credit_used < c_credit_limit);
    assign bus.imem_req_addr  = r_fetch_pc;
    assign w_req_fire         = bus.imem_req_valid && bus.imem_req_ready;

    assign w_rsp_stale = (r_drop != '0);
    assign w_rsp_dec   = c_cnt_w'(bus.imem_rsp_valid);
    assign w_push      = bus.imem_rsp_valid && !w_rsp_stale && !bus.redirect_valid;

    // Gated by rst so the head is hidden during the reset cycle itself.
    assign bus.out_valid = !rst && !w_fifo_empty && !bus.redirect_valid;
    assign w_pop         = bus.out_valid && bus.out_ready;

    assign w_push_entry = '{pc: r_rsp_pc, instr: bus.imem_rsp_data};
    assign w_head       = fetch_entry_t'(w_pop_data);
    assign bus.out_pc    = w_head.pc;
    assign bus.out_instr = bus.out_valid ? w_head.instr : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (bus.redirect_valid) begin
            r_fetch_pc    <= align_pc(bus.redirect_pc);
            r_rsp_pc      <= align_pc(bus.redirect_pc);
            // Whatever is still in flight after this cycle belongs to the old path.
            r_outstanding <= r_outstanding - w_rsp_dec;
            r_drop        <= r_outstanding - w_rsp_dec;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + XLEN'(4);
            end
            if (bus.imem_rsp_valid && w_rsp_stale) begin
                r_drop <= r_drop - c_cnt_w'(1);
            end
            r_outstanding <= r_outstanding + c_cnt_w'(w_req_fire) - w_rsp_dec;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (bus.redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_count     (w_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    a_push_has_room : assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_fifo_full && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Self-checking bench for instr_fetch_queue. An in-order memory
//               model with configurable latency serves requests; a scoreboard
//               queue of expected {pc, instr} is filled as requests are
//               accepted and drained as IF/ID accepts entries. A redirect
//               vector table exercises PC alignment and address wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;
    import fetch_pkg::*;

    localparam int              DEPTH    = 4;
    localparam logic [31:0]     RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_queue_if bus();

    instr_fetch_queue #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } mem_rsp_t;

    typedef struct {
        logic [31:0] redir_pc;
        logic [31:0] exp_addr0;
        logic [31:0] exp_addr1;
    } redir_vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // per-cycle stimulus controls
    logic        c_rst       = 1'b1;
    logic        c_redir     = 1'b0;
    logic [31:0] c_redir_pc  = '0;
    logic        c_req_ready = 1'b1;
    logic        c_out_ready = 1'b1;
    int          lat_lo      = 1;
    int          lat_hi      = 1;

    // reference model state
    mem_rsp_t     mem_q[$];
    fetch_entry_t sb_q[$];
    int           last_due       = 0;
    int           stale          = 0;
    logic [31:0]  model_fetch_pc = RESET_PC;

    // sampled outputs and statistics
    logic        s_req_valid, s_out_valid;
    logic [31:0] s_req_addr, s_out_pc, s_out_instr;
    int          n_out  = 0;
    int          n_fire = 0;
    logic [31:0] last_out_pc = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, settle, sample, check, update model.
    task automatic cycle();
        mem_rsp_t     r;
        fetch_entry_t e;
        int           mem_pend;
        int           queued;
        logic         rsp_now;
        logic         exp_rv, exp_ov;
        int           lat, due;
        @(negedge clk);
        cyc++;
        rst                = c_rst;
        bus.imem_req_ready = c_req_ready;
        bus.out_ready      = c_out_ready;
        bus.redirect_valid = c_redir;
        bus.redirect_pc    = c_redir_pc;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        if (c_rst) begin
            mem_q.delete();
            sb_q.delete();
            stale          = 0;
            last_due       = cyc;
            model_fetch_pc = RESET_PC;
        end
        mem_pend = mem_q.size();
        rsp_now  = 1'b0;
        if (!c_rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            r = mem_q.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = r.data;
            rsp_now = 1'b1;
        end
        #1;
        s_req_valid = bus.imem_req_valid;
        s_req_addr  = bus.imem_req_addr;
        s_out_valid = bus.out_valid;
        s_out_pc    = bus.out_pc;
        s_out_instr = bus.out_instr;
        if (c_rst) begin
            check("out_valid_in_reset", {31'b0, s_out_valid}, 32'd0);
            return;
        end

        // credit / occupancy expectations from the transaction model
        queued = sb_q.size() - (mem_pend - stale);
        exp_rv = !c_redir && ((sb_q.size() + stale) < DEPTH);
        exp_ov = !c_redir && (queued > 0);
        check("req_valid", {31'b0, s_req_valid}, {31'b0, exp_rv});
        check("out_valid", {31'b0, s_out_valid}, {31'b0, exp_ov});

        if (rsp_now && stale > 0) stale--;

        if (c_redir) begin
            stale = mem_q.size();
            sb_q.delete();
            model_fetch_pc = {c_redir_pc[31:2], 2'b00};
        end else begin
            if (s_req_valid) check("req_addr", s_req_addr, model_fetch_pc);
            if (s_out_valid && c_out_ready) begin
                n_out++;
                last_out_pc = s_out_pc;
                if (sb_q.size() == 0) begin
                    check("unexpected_output_pc", s_out_pc, 32'hDEAD_BEEF);
                end else begin
                    e = sb_q.pop_front();
                    check("out_pc", s_out_pc, e.pc);
                    check("out_instr", s_out_instr, e.instr);
                end
            end
            if (s_req_valid && c_req_ready) begin
                sb_q.push_back('{pc: model_fetch_pc, instr: mem_word(model_fetch_pc)});
                model_fetch_pc = model_fetch_pc + 32'd4;
            end
        end
        // memory serves whatever it accepted, in order
        if (s_req_valid && c_req_ready) begin
            n_fire++;
            lat = $urandom_range(lat_hi, lat_lo);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{due: due, data: mem_word(s_req_addr)});
        end
        check("credit_bound", {31'b0, ((sb_q.size() + stale) <= DEPTH)}, 32'd1);
    endtask

    task automatic do_reset();
        c_rst = 1'b1; c_redir = 1'b0; c_req_ready = 1'b1; c_out_ready = 1'b1;
        repeat (2) cycle();
        c_rst = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        redir_vec_t vecs[5];
        int         n0;
        vecs[0] = '{redir_pc: 32'h0000_0203, exp_addr0: 32'h0000_0200, exp_addr1: 32'h0000_0204};
        vecs[1] = '{redir_pc: 32'hFFFF_FFFC, exp_addr0: 32'hFFFF_FFFC, exp_addr1: 32'h0000_0000};
        vecs[2] = '{redir_pc: 32'hFFFF_FFFF, exp_addr0: 32'hFFFF_FFFC, exp_addr1: 32'h0000_0000};
        vecs[3] = '{redir_pc: 32'h0000_0100, exp_addr0: 32'h0000_0100, exp_addr1: 32'h0000_0104};
        vecs[4] = '{redir_pc: 32'h0000_0001, exp_addr0: 32'h0000_0000, exp_addr1: 32'h0000_0004};

        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;

        // --- streaming, zero-wait memory ---
        lat_lo = 1; lat_hi = 1;
        do_reset();
        n_out = 0;
        cycle();
        check("reset_req_valid", {31'b0, s_req_valid}, 32'd1);
        check("reset_req_addr", s_req_addr, RESET_PC);
        repeat (19) cycle();
        check("stream_throughput", n_out, 32'd18);

        // --- stall: exactly DEPTH requests, then drain in order ---
        do_reset();
        c_out_ready = 1'b0; n_fire = 0; n_out = 0;
        repeat (10) cycle();
        check("stall_fires", n_fire, DEPTH);
        check("stall_req_valid_low", {31'b0, s_req_valid}, 32'd0);
        c_out_ready = 1'b1;
        repeat (4) cycle();
        check("stall_drain_count", n_out, 32'd4);
        check("stall_drain_last_pc", last_out_pc, 32'h0000_000C);

        // --- redirect with 3 responses in flight (latency 3) ---
        lat_lo = 3; lat_hi = 3;
        do_reset();
        for (int k = 0; k < 30 && mem_q.size() != 3; k++) cycle();
        check("inflight_3_reached", mem_q.size(), 32'd3);
        c_redir = 1'b1; c_redir_pc = 32'h0000_0100;
        cycle();
        c_redir = 1'b0;
        n0 = n_out;
        for (int k = 0; k < 20 && n_out == n0; k++) cycle();
        check("redir3_output_seen", {31'b0, (n_out > n0)}, 32'd1);
        check("redir3_first_pc", last_out_pc, 32'h0000_0100);
        repeat (10) cycle();

        // --- redirect together with response and pop ---
        lat_lo = 1; lat_hi = 1;
        do_reset();
        repeat (6) cycle();
        c_redir = 1'b1; c_redir_pc = 32'h0000_0300;
        cycle();
        check("redir_pop_out_valid", {31'b0, s_out_valid}, 32'd0);
        c_redir = 1'b0;
        n0 = n_out;
        for (int k = 0; k < 10 && n_out == n0; k++) cycle();
        check("redir_pop_first_pc", last_out_pc, 32'h0000_0300);

        // --- redirect vector table: alignment and wrap ---
        for (int i = 0; i < 5; i++) begin
            c_redir = 1'b1; c_redir_pc = vecs[i].redir_pc;
            cycle();
            c_redir = 1'b0;
            cycle();
            check("tbl_req_valid", {31'b0, s_req_valid}, 32'd1);
            check("tbl_addr0", s_req_addr, vecs[i].exp_addr0);
            cycle();
            check("tbl_addr1", s_req_addr, vecs[i].exp_addr1);
            repeat (4) cycle();
        end

        // --- random back-pressure, latency 1..5, occasional redirects ---
        lat_lo = 1; lat_hi = 5;
        do_reset();
        n_out = 0;
        for (int k = 0; k < 3000; k++) begin
            c_req_ready = ($urandom_range(99, 0) < 70);
            c_out_ready = ($urandom_range(99, 0) < 60);
            c_redir     = ($urandom_range(99, 0) < 3);
            c_redir_pc  = $urandom;
            cycle();
        end
        c_redir = 1'b0;
        check("random_progress", {31'b0, (n_out > 200)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
